// File: rtl/audio_nios_pio_in_dbnc.sv
// Avalon-MM input PIO: synchroniser, per-bit debounce, selectable edge capture
// (write-1-to-clear) and a maskable level interrupt for board switches and keys.
module audio_nios_pio_in_dbnc #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DBNC_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DBNC_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

  localparam logic [2:0] ADDR_DATA  = 3'd0;
  localparam logic [2:0] ADDR_RAW   = 3'd1;
  localparam logic [2:0] ADDR_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE  = 3'd3;
  localparam logic [2:0] ADDR_RISE  = 3'd4;
  localparam logic [2:0] ADDR_FALL  = 3'd5;
  localparam logic [2:0] ADDR_DBNC  = 3'd6;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync_q;
  logic [WIDTH-1:0]                  w_stable;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_edge_cap;
  logic [WIDTH-1:0]                  r_irq_mask;
  logic [WIDTH-1:0]                  r_rise_en;
  logic [WIDTH-1:0]                  r_fall_en;
  logic [WIDTH-1:0]                  r_dbnc_en;
  logic [WIDTH-1:0]                  w_rise;
  logic [WIDTH-1:0]                  w_fall;
  logic [WIDTH-1:0]                  w_event;
  logic [WIDTH-1:0]                  w_clr;
  logic [WIDTH-1:0]                  w_wdata;
  logic                              w_wr;
  logic [31:0]                       w_rd_mux;
  logic [31:0]                       w_unused_wdata;

  assign w_wr           = chipselect & ~write_n;
  assign w_wdata        = writedata[WIDTH-1:0];
  assign w_unused_wdata = writedata;

  // Stage 0 samples the pins; the last stage is the synchronised value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
    end
  end

  assign w_sync_q = r_sync[SYNC_STAGES-1];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dbnc
      logic [CNT_W-1:0] r_cnt;
      logic             r_stable;

      // Counts consecutive disagreeing cycles; any agreement restarts the interval.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (!r_dbnc_en[gi]) begin
          r_cnt    <= '0;
          r_stable <= w_sync_q[gi];
        end else if (w_sync_q[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt    <= '0;
          r_stable <= w_sync_q[gi];
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_stable[gi] = r_stable;
    end
  endgenerate

  assign w_rise  = w_stable & ~r_prev;
  assign w_fall  = ~w_stable & r_prev;
  assign w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr   = (w_wr && (address == ADDR_EDGE)) ? w_wdata : '0;

  // A new event overrides a same-cycle clear so nothing is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev     <= '0;
      r_edge_cap <= '0;
    end else begin
      r_prev     <= w_stable;
      r_edge_cap <= w_event | (r_edge_cap & ~w_clr);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
      r_rise_en  <= '1;
      r_fall_en  <= '0;
      r_dbnc_en  <= '1;
    end else if (w_wr) begin
      case (address)
        ADDR_MASK: r_irq_mask <= w_wdata;
        ADDR_RISE: r_rise_en  <= w_wdata;
        ADDR_FALL: r_fall_en  <= w_wdata;
        ADDR_DBNC: r_dbnc_en  <= w_wdata;
        default:   ;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_stable;
      ADDR_RAW:  w_rd_mux[WIDTH-1:0] = w_sync_q;
      ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_irq_mask;
      ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge_cap;
      ADDR_RISE: w_rd_mux[WIDTH-1:0] = r_rise_en;
      ADDR_FALL: w_rd_mux[WIDTH-1:0] = r_fall_en;
      ADDR_DBNC: w_rd_mux[WIDTH-1:0] = r_dbnc_en;
      default:   w_rd_mux = '0;
    endcase
  end

  // Read data is registered every cycle from the presented address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= w_rd_mux;
    end
  end

  assign irq = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_audio_nios_pio_in_dbnc.sv
// Bench for audio_nios_pio_in_dbnc: directed bus/pin stimulus, a window-based
// behavioural model checked every cycle, plus literal register expectations.
`timescale 1ns/1ps
module tb_audio_nios_pio_in_dbnc;
  localparam int W = 10;
  localparam int S = 2;
  localparam int D = 4;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [2:0]    address    = 3'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = 32'd0;
  logic [W-1:0]  in_port    = '0;
  logic [31:0]   readdata;
  logic          irq;

  audio_nios_pio_in_dbnc #(
    .WIDTH(W), .SYNC_STAGES(S), .DBNC_CYCLES(D)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: stable flips only after D consecutive disagreeing samples, all later
  // than the last flip / reset / bypassed cycle of that bit.
  logic [W-1:0] m_sync = '0, m_stable = '0, m_prev = '0, m_cap = '0;
  logic [W-1:0] m_mask = '0, m_rise_en = '1, m_fall_en = '0, m_dben = '1;
  logic [31:0]  m_rdata = '0;
  logic [W-1:0] m_ip[$];
  logic [W-1:0] m_seen[$];
  int           m_n = 0;
  int           m_last[W];
  logic [W-1:0] m_stable_n, m_ev, m_clr, m_tmp;
  logic         m_ok;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_sync = '0; m_stable = '0; m_prev = '0; m_cap = '0;
      m_mask = '0; m_rise_en = '1; m_fall_en = '0; m_dben = '1;
      m_rdata = '0;
      m_ip.delete();
      m_seen.delete();
      m_n = 0;
      foreach (m_last[i]) m_last[i] = 0;
    end else begin
      m_n++;
      m_seen.push_back(m_sync);
      m_rdata = '0;
      case (address)
        3'd0: m_rdata[W-1:0] = m_stable;
        3'd1: m_rdata[W-1:0] = m_sync;
        3'd2: m_rdata[W-1:0] = m_mask;
        3'd3: m_rdata[W-1:0] = m_cap;
        3'd4: m_rdata[W-1:0] = m_rise_en;
        3'd5: m_rdata[W-1:0] = m_fall_en;
        3'd6: m_rdata[W-1:0] = m_dben;
        default: m_rdata = '0;
      endcase
      for (int i = 0; i < W; i++) begin
        if (!m_dben[i]) begin
          m_stable_n[i] = m_sync[i];
          m_last[i] = m_n;
        end else begin
          m_ok = (m_n - D + 1) > m_last[i];
          for (int k = m_n - D + 1; k <= m_n; k++) begin
            if (m_ok) begin
              m_tmp = m_seen[k-1];
              if (m_tmp[i] == m_stable[i]) m_ok = 1'b0;
            end
          end
          m_stable_n[i] = m_ok ? ~m_stable[i] : m_stable[i];
          if (m_ok) m_last[i] = m_n;
        end
      end
      m_ev  = (m_stable & ~m_prev & m_rise_en) | (~m_stable & m_prev & m_fall_en);
      m_clr = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
      m_cap = m_ev | (m_cap & ~m_clr);
      m_prev = m_stable;
      m_stable = m_stable_n;
      if (chipselect && !write_n) begin
        case (address)
          3'd2: m_mask    = writedata[W-1:0];
          3'd4: m_rise_en = writedata[W-1:0];
          3'd5: m_fall_en = writedata[W-1:0];
          3'd6: m_dben    = writedata[W-1:0];
          default: ;
        endcase
      end
      m_ip.push_back(in_port);
      m_sync = (m_n >= S) ? m_ip[m_n-S] : '0;
    end
  end

  bit run_cmp = 1'b0;

  initial forever begin
    @(negedge clk);
    if (run_cmp) begin
      chk("cyc_readdata", readdata, m_rdata);
      chk("cyc_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a; chipselect = 1'b1;
    tick(1);
    chipselect = 1'b0;
    chk(name, readdata, exp);
    $display("read addr=%0d data=0x%0h exp=0x%0h", a, readdata, exp);
  endtask

  logic [31:0] rst_exp [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3FF, 32'h0, 32'h3FF, 32'h0};

  initial begin
    tick(3);
    reset_n = 1'b1;
    run_cmp = 1'b1;

    for (int a = 0; a < 8; a++) rd(3'(a), rst_exp[a], "reset_reg");
    chk("reset_irq", {31'd0, irq}, 32'd0);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, 32'd0, "addr7_ignored");

    // Debounced rising edge on bit 3
    wr(3'd2, 32'h008);
    address = 3'd0;
    in_port = 10'h008;
    tick(6);
    chk("data_e6", readdata, 32'h000);
    chk("irq_e6", {31'd0, irq}, 32'd0);
    tick(1);
    chk("data_e7", readdata, 32'h008);
    chk("irq_e7", {31'd0, irq}, 32'd1);
    address = 3'd3;
    tick(1);
    chk("cap_e8", readdata, 32'h008);
    wr(3'd3, 32'h3FF);
    chk("irq_after_w1c", {31'd0, irq}, 32'd0);

    // Glitch rejection, then the same pulse with debounce bypassed
    address = 3'd3;
    in_port = 10'h009;
    tick(3);
    in_port = 10'h008;
    tick(10);
    chk("glitch_cap", readdata, 32'h000);
    address = 3'd0;
    tick(1);
    chk("glitch_data", readdata, 32'h008);
    wr(3'd6, 32'h3FE);
    address = 3'd3;
    in_port = 10'h009;
    tick(3);
    in_port = 10'h008;
    tick(1);
    chk("nodb_cap_e4", readdata, 32'h000);
    tick(1);
    chk("nodb_cap_e5", readdata, 32'h001);
    tick(5);
    wr(3'd3, 32'h001);
    wr(3'd6, 32'h3FF);

    // Falling-edge only, then any-edge
    wr(3'd4, 32'h000);
    wr(3'd5, 32'h001);
    in_port = 10'h009;
    tick(10);
    rd(3'd3, 32'h000, "fall_no_rise");
    in_port = 10'h008;
    tick(10);
    rd(3'd3, 32'h001, "fall_cap");
    wr(3'd3, 32'h001);
    wr(3'd4, 32'h3FF);
    in_port = 10'h009;
    tick(10);
    wr(3'd3, 32'h001);
    address = 3'd3;
    in_port = 10'h008;
    tick(6);
    in_port = 10'h009;
    tick(1);
    chk("any_fall_e7", readdata, 32'h000);
    tick(1);
    chk("any_fall_e8", readdata, 32'h001);
    wr(3'd3, 32'h001);
    rd(3'd3, 32'h000, "any_cleared");
    tick(7);
    rd(3'd3, 32'h001, "any_rise");

    // W1C partial clear
    wr(3'd3, 32'h3FF);
    in_port = 10'h001;
    tick(10);
    in_port = 10'h00D;
    tick(10);
    rd(3'd3, 32'h00C, "w1c_pre");
    wr(3'd3, 32'h004);
    rd(3'd3, 32'h008, "w1c_post");

    // Clear and capture on bit 3 in the same cycle
    wr(3'd3, 32'h3FF);
    in_port = 10'h005;
    tick(10);
    in_port = 10'h00D;
    tick(6);
    wr(3'd3, 32'h008);
    chk("simul_irq", {31'd0, irq}, 32'd1);
    rd(3'd3, 32'h008, "simul_cap");

    // Reset in the middle of a debounce interval
    wr(3'd3, 32'h3FF);
    wr(3'd5, 32'h3FF);
    in_port = 10'h005;
    tick(4);
    #2;
    reset_n = 1'b0;
    in_port = '0;
    tick(3);
    #2;
    reset_n = 1'b1;
    tick(20);
    chk("rst2_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) rd(3'(a), rst_exp[a], "rst2_reg");

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_nios_pio_in_dbnc.md
# audio_nios_pio_in_dbnc

Parametrised Avalon-MM input PIO for the Nios II audio subsystem, replacing the fixed 10-bit switch/key PIO. It provides configurable synchroniser depth, per-bit debounce, per-bit rising/falling/any edge selection, write-1-to-clear edge capture and a maskable level interrupt. It sits on the Nios data master next to the audio codec control slaves and serves board switches and keys.

## Interface
Parameters:
- WIDTH, 10: number of input bits, 1..32.
- SYNC_STAGES, 2: flip-flop synchroniser depth on in_port, 2..4.
- DBNC_CYCLES, 50000: consecutive stable clk cycles required before a debounced bit changes, 1 or more. Counter width is clog2(DBNC_CYCLES)+1.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- address, input, 3: register word address.
- chipselect, input, 1: slave select.
- write_n, input, 1: active-low write strobe.
- writedata, input, 32: write data; bits above WIDTH are ignored.
- in_port, input, WIDTH: asynchronous external inputs.
- readdata, output, 32: registered read data, zero-extended above WIDTH.
- irq, output, 1: level interrupt, |(edge_capture & irq_mask).

## Operation
- Register map (address: name, access, reset value):
  - 0: data, RO, 0. Debounced value.
  - 1: raw, RO, 0. Synchroniser output.
  - 2: irq_mask, RW, 0.
  - 3: edge_capture, W1C, 0.
  - 4: rise_en, RW, all ones.
  - 5: fall_en, RW, 0.
  - 6: dbnc_en, RW, all ones.
  - 7: reads 0; writes are ignored.
- Synchroniser: SYNC_STAGES flops per bit, all reset to 0. sync_q is the last stage.
- Debounce, per bit i with dbnc_en[i]=1: cnt[i] increments each cycle that sync_q[i] != stable[i] and clears to 0 on any cycle they are equal. When cnt[i]==DBNC_CYCLES-1 and the bits still differ, stable[i] <= sync_q[i] and cnt[i] <= 0.
- Debounce, per bit i with dbnc_en[i]=0: stable[i] <= sync_q[i] every cycle and cnt[i] is held at 0. Clearing dbnc_en[i] mid-count aborts that count.
- Edge detect: prev[i] <= stable[i] every cycle.
  - rise[i] = stable[i] & ~prev[i]; fall[i] = ~stable[i] & prev[i].
  - event[i] = (rise[i] & rise_en[i]) | (fall[i] & fall_en[i]). Setting both enables gives any-edge capture.
- edge_capture[i]: set on event[i]; cleared by a write to address 3 with writedata[i]=1. A write with writedata[i]=0 leaves the bit unchanged.
- Simultaneous set and clear on the same bit in the same cycle: set wins, so no event is lost.
- Writing 0 to rise_en or fall_en does not clear already captured bits.

## Timing
- A write takes effect on the clk edge where chipselect=1 and write_n=0.
- Read latency is 1 cycle. readdata is registered every cycle from the current address, regardless of chipselect, and resets to 0.
- irq is combinational from the registers and is 0 after reset. It deasserts in the cycle after the W1C write edge.
- in_port change, with debounce on: in_port is sampled at edge 1, sync_q updates at edge SYNC_STAGES, stable at edge SYNC_STAGES+DBNC_CYCLES, edge_capture at edge SYNC_STAGES+DBNC_CYCLES+1.
- in_port change, with debounce off: stable at edge SYNC_STAGES+1, edge_capture at edge SYNC_STAGES+2.
- A pulse on sync_q shorter than DBNC_CYCLES cycles produces no change in stable and no capture.
- Reset asserted mid-count clears all state (sync, stable, prev, cnt, registers) immediately. After release, no edge is reported unless an input later differs from 0 for a full debounce interval.
- Inputs held at 1 through reset do produce a rising event after release, following the latency rules above. Firmware clears it at init.

## Test plan
Bench parameters: WIDTH=10, SYNC_STAGES=2, DBNC_CYCLES=4.
- Reset check: read all 8 addresses -> values 0,0,0,0,0x3FF,0,0x3FF,0; irq=0.
- Debounced rising edge: in_port[3] goes 0->1 before edge 1 -> data[3]=1 after edge 6, edge_capture=0x008 after edge 7. With irq_mask=0x008, irq=1 from edge 7.
- Glitch rejection: 3-cycle pulse on in_port[0] -> data and edge_capture remain 0. The same test with dbnc_en[0]=0 -> edge_capture[0]=1 after edge 4.
- Falling edge mode: fall_en=0x001, rise_en=0, in_port[0] 1->0 -> only a fall is captured. With both enables set, the 1->0->1 sequence (each level held 6 cycles) captures on both edges.
- W1C: edge_capture=0x00C, write 0x004 to address 3 -> reads 0x008. A write clearing bit 3 in the same cycle an event on bit 3 is detected -> bit 3 stays 1.
- Reset mid-debounce: assert reset_n at cnt=2 -> all registers return to reset values and no spurious capture follows release while in_port=0.
